// File: rtl/alu_cmd_issue.sv
// alu_cmd_issue: command FIFO in front of an external combinational ALU,
// with a one-entry registered response stage (IDLE/HOLD).
// Ports:
//   clk, reset (async, active-low)
//   cmd_valid/cmd_ready, cmd_op1/op2/opcode/tag : upstream command
//   alu_operand1/2, alu_opcode -> ALU ; alu_result <- ALU
//   rsp_valid/rsp_ready, rsp_result/tag/opcode  : registered response
//   count : FIFO occupancy
module alu_cmd_issue #(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [7:0]             cmd_op1,
   input  logic [7:0]             cmd_op2,
   input  logic [1:0]             cmd_opcode,
   input  logic [3:0]             cmd_tag,
   output logic [7:0]             alu_operand1,
   output logic [7:0]             alu_operand2,
   output logic [1:0]             alu_opcode,
   input  logic [15:0]            alu_result,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [15:0]            rsp_result,
   output logic [3:0]             rsp_tag,
   output logic [1:0]             rsp_opcode,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef enum logic {
      S_IDLE,
      S_HOLD
   } state_t;

   logic [7:0]    mem_op1 [DEPTH];
   logic [7:0]    mem_op2 [DEPTH];
   logic [1:0]    mem_opc [DEPTH];
   logic [3:0]    mem_tag [DEPTH];

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   state_t        state;
   logic          not_empty;
   logic          push;
   logic          pop;

   assign not_empty = (count != '0);

   // Derived from the registered count only: a pop on the
   // same edge never opens a slot early.
   assign cmd_ready = (count < FULL);
   assign push      = cmd_valid && cmd_ready;

   // Response register is free when idle or being drained.
   assign pop       = not_empty &&
                      ((state == S_IDLE) || rsp_ready);

   assign rsp_valid = (state == S_HOLD);

   assign alu_operand1 = not_empty ? mem_op1[rd_ptr] : 8'd0;
   assign alu_operand2 = not_empty ? mem_op2[rd_ptr] : 8'd0;
   assign alu_opcode   = not_empty ? mem_opc[rd_ptr] : 2'd0;

   // Storage is not reset; occupancy alone marks valid entries.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_op1[wr_ptr] <= cmd_op1;
         mem_op2[wr_ptr] <= cmd_op2;
         mem_opc[wr_ptr] <= cmd_opcode;
         mem_tag[wr_ptr] <= cmd_tag;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // DEPTH is a power of two, so pointers wrap naturally.
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         rsp_result <= '0;
         rsp_tag    <= '0;
         rsp_opcode <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (pop) begin
                  state      <= S_HOLD;
                  rsp_result <= alu_result;
                  rsp_tag    <= mem_tag[rd_ptr];
                  rsp_opcode <= mem_opc[rd_ptr];
               end
            end
            S_HOLD: begin
               if (pop) begin
                  rsp_result <= alu_result;
                  rsp_tag    <= mem_tag[rd_ptr];
                  rsp_opcode <= mem_opc[rd_ptr];
               end else if (rsp_ready) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_cmd_issue.sv
// tb_alu_cmd_issue: table vectors + scoreboard for alu_cmd_issue,
// with a behavioural ALU closing the loop on alu_*.
module tb_alu_cmd_issue;

   localparam int DEPTH = 4;

   logic                   clk;
   logic                   reset;
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic [7:0]             cmd_op1;
   logic [7:0]             cmd_op2;
   logic [1:0]             cmd_opcode;
   logic [3:0]             cmd_tag;
   logic [7:0]             alu_operand1;
   logic [7:0]             alu_operand2;
   logic [1:0]             alu_opcode;
   logic [15:0]            alu_result;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [15:0]            rsp_result;
   logic [3:0]             rsp_tag;
   logic [1:0]             rsp_opcode;
   logic [$clog2(DEPTH):0] count;

   logic [15:0]            drv_exp;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [1:0]  op;
      logic [3:0]  tag;
      logic [15:0] exp;
   } vec_t;

   typedef struct {
      logic [15:0] res;
      logic [3:0]  tag;
      logic [1:0]  op;
   } sb_t;

   vec_t vt [16];
   sb_t  sb_q [$];
   int   n_vec   = 0;
   int   n_err   = 0;
   int   rsp_cnt = 0;

   alu_cmd_issue #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op1      (cmd_op1),
      .cmd_op2      (cmd_op2),
      .cmd_opcode   (cmd_opcode),
      .cmd_tag      (cmd_tag),
      .alu_operand1 (alu_operand1),
      .alu_operand2 (alu_operand2),
      .alu_opcode   (alu_opcode),
      .alu_result   (alu_result),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_result   (rsp_result),
      .rsp_tag      (rsp_tag),
      .rsp_opcode   (rsp_opcode),
      .count        (count)
   );

   function automatic logic [15:0] alu_fn(
      logic [7:0] a, logic [7:0] b, logic [1:0] op);
      case (op)
         2'd0:    return 16'(a) + 16'(b);
         2'd1:    return 16'(a) * 16'(b);
         2'd2:    return 16'(a) - 16'(b);
         default: return {8'h00, a ^ b};
      endcase
   endfunction

   assign alu_result = alu_fn(alu_operand1, alu_operand2,
                              alu_opcode);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(string nm, logic [31:0] act,
                      logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: push on accepted command, pop on accepted response.
   always @(negedge clk) begin
      if (reset) begin
         if (rsp_valid && rsp_ready) begin
            rsp_cnt++;
            n_vec++;
            if (sb_q.size() == 0) begin
               n_err++;
               $display("FAIL rsp_unexpected: got tag %0h res %0h want none",
                        rsp_tag, rsp_result);
            end else begin
               sb_t e;
               e = sb_q.pop_front();
               if (rsp_result !== e.res || rsp_tag !== e.tag ||
                   rsp_opcode !== e.op) begin
                  n_err++;
                  $display("FAIL rsp_sb: got res %0h tag %0h op %0h want res %0h tag %0h op %0h",
                           rsp_result, rsp_tag, rsp_opcode,
                           e.res, e.tag, e.op);
               end
            end
         end
         if (cmd_valid && cmd_ready)
            sb_q.push_back('{drv_exp, cmd_tag, cmd_opcode});
      end
   end

   task automatic drive(vec_t v, logic [3:0] tg);
      cmd_op1    = v.a;
      cmd_op2    = v.b;
      cmd_opcode = v.op;
      cmd_tag    = tg;
      drv_exp    = v.exp;
      cmd_valid  = 1'b1;
   endtask

   task automatic wait_acc(string nm);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 50 && !ok; k++) begin
         @(negedge clk);
         ok = cmd_ready;
         step();
      end
      cmd_valid = 1'b0;
      if (!ok) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: got no accept want accept", nm);
      end
   endtask

   task automatic send(vec_t v, logic [3:0] tg);
      drive(v, tg);
      wait_acc("send");
   endtask

   task automatic drain(string nm);
      bit done;
      done      = 1'b0;
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      for (int k = 0; k < 100 && !done; k++) begin
         @(negedge clk);
         done = (count == '0) && !rsp_valid;
         step();
      end
      chk({nm, "_drain"}, 32'(done), 32'd1);
      chk({nm, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  s0;
      bit  acc;
      vec_t rv;

      vt[0]  = '{8'd200, 8'd100, 2'd0, 4'd3,  16'd300};
      vt[1]  = '{8'd255, 8'd255, 2'd1, 4'd1,  16'hFE01};
      vt[2]  = '{8'd3,   8'd5,   2'd2, 4'd2,  16'hFFFE};
      vt[3]  = '{8'hF0,  8'h0F,  2'd3, 4'd4,  16'h00FF};
      vt[4]  = '{8'd1,   8'd1,   2'd0, 4'd5,  16'h0002};
      vt[5]  = '{8'd16,  8'd16,  2'd1, 4'd6,  16'h0100};
      vt[6]  = '{8'd0,   8'd1,   2'd2, 4'd7,  16'hFFFF};
      vt[7]  = '{8'hAA,  8'hFF,  2'd3, 4'd8,  16'h0055};
      vt[8]  = '{8'hFF,  8'hFF,  2'd0, 4'd9,  16'h01FE};
      vt[9]  = '{8'd200, 8'd100, 2'd2, 4'd10, 16'h0064};
      vt[10] = '{8'd12,  8'd10,  2'd1, 4'd11, 16'h0078};
      vt[11] = '{8'd0,   8'd0,   2'd3, 4'd12, 16'h0000};
      vt[12] = '{8'd128, 8'd2,   2'd1, 4'd13, 16'h0100};
      vt[13] = '{8'd7,   8'd9,   2'd0, 4'd14, 16'h0010};
      vt[14] = '{8'd100, 8'd200, 2'd2, 4'd15, 16'hFF9C};
      vt[15] = '{8'h5A,  8'hA5,  2'd3, 4'd0,  16'h00FF};

      cmd_valid  = 1'b0;
      cmd_op1    = '0;
      cmd_op2    = '0;
      cmd_opcode = '0;
      cmd_tag    = '0;
      drv_exp    = '0;
      rsp_ready  = 1'b0;

      // Reset state, before any clock edge.
      reset = 1'b1;
      #1 reset = 1'b0;
      #2;
      chk("rst_count",  32'(count),        32'd0);
      chk("rst_ready",  32'(cmd_ready),    32'd1);
      chk("rst_rvalid", 32'(rsp_valid),    32'd0);
      chk("rst_result", 32'(rsp_result),   32'd0);
      chk("rst_tag",    32'(rsp_tag),      32'd0);
      chk("rst_opcode", 32'(rsp_opcode),   32'd0);
      chk("rst_alu_a",  32'(alu_operand1), 32'd0);
      chk("rst_alu_op", 32'(alu_opcode),   32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      // Single ADD with minimum latency.
      rsp_ready = 1'b1;
      send(vt[0], vt[0].tag);
      @(negedge clk);
      chk("one_count1", 32'(count),        32'd1);
      chk("one_nrsp",   32'(rsp_valid),    32'd0);
      chk("one_alu_a",  32'(alu_operand1), 32'd200);
      step();
      @(negedge clk);
      chk("one_rvalid", 32'(rsp_valid),  32'd1);
      chk("one_result", 32'(rsp_result), 32'd300);
      chk("one_tag",    32'(rsp_tag),    32'd3);
      chk("one_count0", 32'(count),      32'd0);
      step();
      @(negedge clk);
      chk("one_idle", 32'(rsp_valid), 32'd0);
      step();

      // Streaming: table applied back to back, tags 0..15.
      s0 = rsp_cnt;
      for (int i = 0; i < 16; i++)
         send(vt[i], 4'(i));
      @(negedge clk);
      step();
      @(negedge clk);
      #1;
      chk("stream_rate", 32'(rsp_cnt - s0), 32'd16);
      step();
      drain("stream");

      // Fill with rsp_ready low, stall, then release.
      rsp_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         drive(vt[i], vt[i].tag);
         @(negedge clk);
         chk("fill_ready", 32'(cmd_ready), 32'd1);
         step();
      end
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("fill_count3", 32'(count),      32'd3);
      chk("fill_rvalid", 32'(rsp_valid),  32'd1);
      chk("fill_hold",   32'(rsp_result), 32'hFE01);
      step();
      send(vt[5], vt[5].tag);
      drive(vt[6], vt[6].tag);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("full_ready", 32'(cmd_ready),  32'd0);
         chk("full_count", 32'(count),      32'd4);
         chk("full_hold",  32'(rsp_result), 32'hFE01);
         chk("full_tag",   32'(rsp_tag),    32'd1);
         step();
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("full_pop_ready", 32'(cmd_ready), 32'd0);
      step();
      wait_acc("full_retry");
      drain("fill");

      // Asynchronous reset with queued and held commands.
      rsp_ready = 1'b0;
      for (int i = 7; i <= 10; i++)
         send(vt[i], vt[i].tag);
      @(negedge clk);
      chk("pre_rst_rvalid", 32'(rsp_valid), 32'd1);
      chk("pre_rst_count",  32'(count),     32'd3);
      step();
      #2;
      reset = 1'b0;
      sb_q.delete();
      #1;
      chk("arst_rvalid", 32'(rsp_valid),    32'd0);
      chk("arst_count",  32'(count),        32'd0);
      chk("arst_ready",  32'(cmd_ready),    32'd1);
      chk("arst_result", 32'(rsp_result),   32'd0);
      chk("arst_tag",    32'(rsp_tag),      32'd0);
      chk("arst_alu_b",  32'(alu_operand2), 32'd0);
      step();
      reset     = 1'b1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("no_stale_rvalid", 32'(rsp_valid), 32'd0);
         chk("no_stale_count",  32'(count),     32'd0);
         step();
      end
      drive(vt[11], vt[11].tag);
      @(negedge clk);
      chk("first_push_ready", 32'(cmd_ready), 32'd1);
      step();
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("first_push_count", 32'(count), 32'd1);
      step();
      drain("post_rst");

      // Random cmd_valid / rsp_ready.
      for (int c = 0; c < 1000; c++) begin
         if (!cmd_valid && $urandom_range(0, 2) != 0) begin
            rv.a   = 8'($urandom);
            rv.b   = 8'($urandom);
            rv.op  = 2'($urandom_range(0, 3));
            rv.tag = 4'($urandom);
            rv.exp = alu_fn(rv.a, rv.b, rv.op);
            drive(rv, rv.tag);
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         acc = cmd_valid && cmd_ready;
         step();
         if (acc) cmd_valid = 1'b0;
      end
      drain("random");

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
